hex_display_scan: RTL and testbench

Multiplexed, time-scanned driver for a bank of NUM_DIGITS common-anode seven-segment digits. It is the clocked, multi-digit successor to the single-digit hex decoder.
- Holds a captured hex word and cycles one digit at a time at a programmable refresh rate.
- Inserts a dead-time blank between digits to suppress ghosting.
- Supports per-digit enable and leading-zero blanking.
- Sits between the status/debug registers (tracking channel, PRN, lock state) and the board display pins.

---
 rtl/hex_display_scan.sv | 152 +++++++++++++++
 tb/tb_hex_display_scan.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/hex_display_scan.sv
// rtl/hex_display_scan.sv - time-multiplexed seven-segment scan driver; optional blink via `HEX_BLINK_EN
module hex_display_scan #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1024,
  parameter int DEAD_CYCLES = 2,
  parameter int BLINK_DIV   = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lzb,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [6:0]              display,
  output logic [NUM_DIGITS-1:0]   digit_sel
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] DEAD_END   = PW'(DEAD_CYCLES);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [6:0]    SEG_OFF    = 7'h7F;

  logic [4*NUM_DIGITS-1:0] hold_q, hold_d;
  logic [PW-1:0]           presc_q, presc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [6:0]              slot_seg_q, slot_seg_d;
  logic [6:0]              display_q, display_d;
  logic [NUM_DIGITS-1:0]   digit_sel_q, digit_sel_d;
  logic                    slot_wrap;
  logic                    frame_wrap;
  logic [3:0]              nibble;
  logic                    upper_zero;
  logic                    blank;
  logic                    blink_blank;

  // Active-low segment pattern for one hex nibble, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    case (n)
      4'h0: hex_to_seg = 7'h40;
      4'h1: hex_to_seg = 7'h79;
      4'h2: hex_to_seg = 7'h24;
      4'h3: hex_to_seg = 7'h30;
      4'h4: hex_to_seg = 7'h19;
      4'h5: hex_to_seg = 7'h12;
      4'h6: hex_to_seg = 7'h02;
      4'h7: hex_to_seg = 7'h78;
      4'h8: hex_to_seg = 7'h00;
      4'h9: hex_to_seg = 7'h10;
      4'hA: hex_to_seg = 7'h08;
      4'hB: hex_to_seg = 7'h03;
      4'hC: hex_to_seg = 7'h46;
      4'hD: hex_to_seg = 7'h21;
      4'hE: hex_to_seg = 7'h06;
      default: hex_to_seg = 7'h0E;
    endcase
  endfunction

`ifdef HEX_BLINK_EN
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_DIV - 1);

  logic [FW-1:0] frame_q, frame_d;
  logic          phase_q, phase_d;

  // Frame counter and blink phase; the new phase applies from the first slot of the new frame.
  always_comb begin
    frame_d = frame_q;
    phase_d = phase_q;
    if (frame_wrap) begin
      if (frame_q == FRAME_LAST) begin
        frame_d = '0;
        phase_d = ~phase_q;
      end else begin
        frame_d = frame_q + 1'b1;
      end
    end
    blink_blank = phase_d & blink_mask[idx_d];
  end

  // Blink state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_q <= '0;
      phase_q <= 1'b0;
    end else begin
      frame_q <= frame_d;
      phase_q <= phase_d;
    end
  end
`else
  logic unused_blink;
  assign unused_blink = ^blink_mask ^ BLINK_DIV[0];
  assign blink_blank  = 1'b0;
`endif

  // Prescaler, digit index and slot-start sampling of the digit pattern.
  always_comb begin
    hold_d     = load ? value : hold_q;
    slot_wrap  = (presc_q == PRESC_LAST);
    frame_wrap = slot_wrap && (idx_q == IDX_LAST);
    presc_d    = slot_wrap ? '0 : presc_q + 1'b1;
    idx_d      = idx_q;
    if (slot_wrap) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    nibble     = 4'(hold_q >> (4 * idx_d));
    upper_zero = ((hold_q >> (4 * idx_d)) == '0);
    blank      = !digit_en[idx_d]
               | (lzb && (idx_d != '0) && upper_zero)
               | blink_blank;

    slot_seg_d = slot_seg_q;
    if (slot_wrap) begin
      slot_seg_d = blank ? SEG_OFF : hex_to_seg(nibble);
    end

    if (presc_d < DEAD_END) begin
      display_d   = SEG_OFF;
      digit_sel_d = '1;
    end else begin
      display_d   = slot_seg_d;
      digit_sel_d = ~(NUM_DIGITS'(1) << idx_d);
    end
  end

  // State and output registers; reset restarts the scan at digit 0 with outputs dark.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q      <= '0;
      presc_q     <= '0;
      idx_q       <= '0;
      slot_seg_q  <= digit_en[0] ? hex_to_seg(4'h0) : SEG_OFF;
      display_q   <= SEG_OFF;
      digit_sel_q <= '1;
    end else begin
      hold_q      <= hold_d;
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      slot_seg_q  <= slot_seg_d;
      display_q   <= display_d;
      digit_sel_q <= digit_sel_d;
    end
  end

  assign display   = display_q;
  assign digit_sel = digit_sel_q;

endmodule

// File: tb/tb_hex_display_scan.sv
// tb/tb_hex_display_scan.sv - scoreboard bench for hex_display_scan against a cycle-count reference model
module tb_hex_display_scan;

  localparam int N = 4;
  localparam int R = 8;
  localparam int D = 2;
  localparam int B = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [4*N-1:0] value = '0;
  logic           load = 1'b0;
  logic [N-1:0]   digit_en = '1;
  logic           lzb = 1'b0;
  logic [N-1:0]   blink_mask = 4'b0001;
  logic [6:0]     display;
  logic [N-1:0]   digit_sel;

  always #5 clk = ~clk;

  hex_display_scan #(
    .NUM_DIGITS (N),
    .REFRESH_DIV(R),
    .DEAD_CYCLES(D),
    .BLINK_DIV  (B)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .value     (value),
    .load      (load),
    .digit_en  (digit_en),
    .lzb       (lzb),
    .blink_mask(blink_mask),
    .display   (display),
    .digit_sel (digit_sel)
  );

  typedef struct packed {
    logic [6:0]   disp;
    logic [N-1:0] sel;
  } exp_t;

  exp_t       exp_q[$];
  int         vectors = 0;
  int         miscompares = 0;
  logic [6:0] seg_tab[16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [15:0] masks[5] = '{16'hFFFF, 16'h00FF, 16'h000F, 16'h0000, 16'hF0F0};

  // Reference: position in the scan is derived purely from clocks elapsed since reset.
  int          m_t = 0;
  logic [15:0] m_hold = '0;
  logic [6:0]  m_snap = 7'h7F;

  function automatic logic [6:0] model_seg(input logic [15:0] h, input int i,
                                           input logic [N-1:0] en, input logic lz,
                                           input logic [N-1:0] bm, input logic ph);
    logic [3:0] nib;
    logic       blank;
    nib   = h[4*i +: 4];
    blank = !en[i] || (lz && i != 0 && (h >> (4 * i)) == 16'h0) || (ph && bm[i]);
    return blank ? 7'h7F : seg_tab[nib];
  endfunction

  function automatic logic blink_phase(input int frame);
`ifdef HEX_BLINK_EN
    return ((frame / B) % 2) == 1;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk) begin
    exp_t       e;
    int         pos;
    int         idx;
    logic [N-1:0] sel;
    if (reset) begin
      m_t    = 0;
      m_hold = '0;
      m_snap = model_seg(16'h0, 0, digit_en, lzb, blink_mask, 1'b0);
      e.disp = 7'h7F;
      e.sel  = '1;
    end else begin
      m_t = m_t + 1;
      pos = m_t % R;
      idx = (m_t / R) % N;
      if (pos == 0) begin
        m_snap = model_seg(m_hold, idx, digit_en, lzb, blink_mask, blink_phase(m_t / (R * N)));
      end
      if (load) m_hold = value;
      if (pos < D) begin
        e.disp = 7'h7F;
        e.sel  = '1;
      end else begin
        sel      = '1;
        sel[idx] = 1'b0;
        e.disp   = m_snap;
        e.sel    = sel;
      end
    end
    exp_q.push_back(e);
  end

  // Monitor: the scan presents a new output every clock; compare away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (display !== e.disp || digit_sel !== e.sel) begin
        miscompares++;
        $display("FAIL scan @%0t: display=%h digit_sel=%h, required display=%h digit_sel=%h",
                 $time, display, digit_sel, e.disp, e.sel);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog @%0t: simulation did not reach the summary", $time);
    $finish;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_state();
    if (display !== 7'h7F || digit_sel !== '1) begin
      miscompares++;
      $display("FAIL reset state @%0t: display=%h digit_sel=%h, required display=7f digit_sel=%h",
               $time, display, digit_sel, {N{1'b1}});
    end
  endtask

  task automatic wait_sel(input logic [N-1:0] target, input int limit);
    int n;
    n = 0;
    while (digit_sel !== target && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (digit_sel !== target) begin
      miscompares++;
      $display("FAIL wait expired @%0t: digit_sel=%h never reached %h within %0d clocks",
               $time, digit_sel, target, limit);
    end
  endtask

  task automatic pulse_load(input logic [15:0] v);
    value = v;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    check_reset_state();
    reset = 1'b0;
  endtask

  initial begin
    cycles(3);
    check_reset_state();
    reset = 1'b0;
    wait_sel(4'hE, 2 * R);
    if (display !== 7'h40) begin
      miscompares++;
      $display("FAIL first digit @%0t: display=%h, required 40", $time, display);
    end
    cycles(40);

    pulse_load(16'h1A3F);
    cycles(2 * N * R);

    lzb = 1'b1;
    pulse_load(16'h0050);
    cycles(2 * N * R);
    pulse_load(16'h0000);
    cycles(2 * N * R);

    lzb = 1'b0;
    do_reset();
    cycles(11);
    pulse_load(16'h1234);
    cycles(2 * N * R);
    digit_en = 4'b1011;
    cycles(2 * N * R);
    digit_en = '1;

    do_reset();
    cycles(2 * R + 4);
    do_reset();
    cycles(N * R);
    pulse_load(16'hBEEF);
    cycles(8 * N * R);

    for (int i = 0; i < 2500; i++) begin
      load = ($urandom_range(0, 7) == 0);
      if (load) value = 16'($urandom) & masks[$urandom_range(0, 4)];
      if ($urandom_range(0, 15) == 0) digit_en = N'($urandom);
      if ($urandom_range(0, 15) == 0) lzb = 1'($urandom);
      if ($urandom_range(0, 31) == 0) blink_mask = N'($urandom);
      reset = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    load  = 1'b0;
    reset = 1'b0;
    cycles(N * R);

    @(posedge clk);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    if (miscompares != 0) $display("FAIL: %0d miscompares", miscompares);
    else $display("PASS");
    $finish;
  end

endmodule
